// File: rtl/c2h_pkg.sv
// Shared constants and types for the C2H stream transmitter.
package c2h_pkg;

  localparam int PACK_W = 4072;
  localparam int BEAT_W = 512;

  // Number of stream beats needed to carry one packed frame.
  function automatic int calc_nbeats(input int pack_w, input int beat_w);
    return (pack_w + beat_w - 1) / beat_w;
  endfunction

  localparam int NBEATS = calc_nbeats(PACK_W, BEAT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/c2h_stream_tx_if.sv
// Packer-side and AXI-Stream C2H signals of the stream transmitter.
interface c2h_stream_tx_if #(
  parameter int PACK_W = c2h_pkg::PACK_W,
  parameter int BEAT_W = c2h_pkg::BEAT_W
);

  logic [PACK_W-1:0]   in_data;
  logic                in_valid;
  logic                data_next;
  logic [BEAT_W-1:0]   m_axis_c2h_tdata_0;
  logic [BEAT_W/8-1:0] m_axis_c2h_tkeep_0;
  logic                m_axis_c2h_tvalid_0;
  logic                m_axis_c2h_tready_0;
  logic                m_axis_c2h_tlast_0;

  // The transmitter drives the stream and the packer release pulse.
  modport master (
    input  in_data, in_valid, m_axis_c2h_tready_0,
    output data_next, m_axis_c2h_tdata_0, m_axis_c2h_tkeep_0,
           m_axis_c2h_tvalid_0, m_axis_c2h_tlast_0
  );

  // Packer plus stream sink, seen from the other side.
  modport slave (
    output in_data, in_valid, m_axis_c2h_tready_0,
    input  data_next, m_axis_c2h_tdata_0, m_axis_c2h_tkeep_0,
           m_axis_c2h_tvalid_0, m_axis_c2h_tlast_0
  );

endinterface

// File: rtl/c2h_stream_tx.sv
// Captures one packed frame and streams it out as NBEATS AXI-Stream beats,
// zero-padded at the MSB end, then releases the packer with data_next.
module c2h_stream_tx #(
  parameter int PACK_W = c2h_pkg::PACK_W,
  parameter int BEAT_W = c2h_pkg::BEAT_W
) (
  input  logic              m_axis_c2h_aclk,
  input  logic              m_axis_c2h_aresetn,
  c2h_stream_tx_if.master   bus,
  output logic [31:0]       frame_cnt,
  output logic              ovf,
  output logic              busy
);

  import c2h_pkg::*;

  localparam int NUM_BEATS = calc_nbeats(PACK_W, BEAT_W);
  localparam int IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int PADDED_W  = NUM_BEATS * BEAT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   beat_idx_q, beat_idx_d;
  logic [PACK_W-1:0]  frame_q, frame_d;
  logic [31:0]        frame_cnt_q, frame_cnt_d;
  logic               ovf_q, ovf_d;

  logic [PADDED_W-1:0] padded;
  logic [BEAT_W-1:0]   beat_data;
  logic                in_send;
  logic                xfer;

  // Zero-extend the captured frame and select the current beat.
  always_comb begin
    padded    = PADDED_W'(frame_q);
    beat_data = padded[int'(beat_idx_q) * BEAT_W +: BEAT_W];
  end

  // Next-state logic: capture in IDLE, step beats on transfers, count in DONE.
  always_comb begin
    state_d     = state_q;
    beat_idx_d  = beat_idx_q;
    frame_d     = frame_q;
    frame_cnt_d = frame_cnt_q;
    ovf_d       = ovf_q | (bus.in_valid && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          frame_d    = bus.in_data;
          beat_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (beat_idx_q == LAST_IDX) begin
            beat_idx_d = '0;
            state_d    = DONE;
          end else begin
            beat_idx_d = beat_idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        frame_cnt_d = frame_cnt_q + 32'd1;
        state_d     = IDLE;
      end
      default: begin
        state_d    = IDLE;
        beat_idx_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      state_q     <= IDLE;
      beat_idx_q  <= '0;
      frame_q     <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_idx_q  <= beat_idx_d;
      frame_q     <= frame_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Outputs decode straight from registers so reset clears them at once.
  always_comb begin
    in_send                 = (state_q == SEND);
    xfer                    = in_send && bus.m_axis_c2h_tready_0;
    bus.m_axis_c2h_tvalid_0 = in_send;
    bus.m_axis_c2h_tdata_0  = in_send ? beat_data : '0;
    bus.m_axis_c2h_tkeep_0  = in_send ? '1 : '0;
    bus.m_axis_c2h_tlast_0  = in_send && (beat_idx_q == LAST_IDX);
    bus.data_next           = (state_q == DONE);
    busy                    = (state_q != IDLE);
    frame_cnt               = frame_cnt_q;
    ovf                     = ovf_q;
  end

endmodule

// File: doc/c2h_stream_tx.md
C2H_STREAM_TX -- requirements
Module: c2h_stream_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock and reset ports SHALL be named m_axis_c2h_aclk and m_axis_c2h_aresetn.
REQ-002 Parameter PACK_W, default 4072: width of the packed frame (4064 IO bits plus an 8-bit sequence number).
REQ-003 Parameter BEAT_W, default 512: AXI-Stream C2H data width.
REQ-004 m_axis_c2h_aclk  input  1  stream clock.
REQ-005 m_axis_c2h_aresetn  input  1  async active-low reset.
REQ-006 in_data  input  PACK_W  packed frame from the packer; it is held stable until data_next.
REQ-007 in_valid  input  1  frame-available indication from the packer.
REQ-008 data_next  output  1  one-cycle pulse that releases the packer for the next frame.
REQ-009 m_axis_c2h_tdata_0  output  BEAT_W  stream data.
REQ-010 m_axis_c2h_tkeep_0  output  BEAT_W/8  byte enables.
REQ-011 m_axis_c2h_tvalid_0  output  1  beat valid.
REQ-012 m_axis_c2h_tready_0  input  1  sink ready.
REQ-013 m_axis_c2h_tlast_0  output  1  last beat of frame.
REQ-014 frame_cnt  output  32  frames fully sent.
REQ-015 ovf  output  1  sticky flag: in_valid was seen while busy.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 NBEATS SHALL equal ceil(PACK_W/BEAT_W), which is 8 by default; the frame SHALL be zero-padded at the MSB end to NBEATS*BEAT_W bits (4096).
REQ-018 The FSM states SHALL be IDLE, SEND and DONE.
REQ-019 IDLE: when in_valid=1, the block SHALL capture in_data into an internal register, clear beat_idx to 0 and enter SEND on the next edge.
REQ-020 SEND: tvalid SHALL be 1, and tdata SHALL equal padded[beat_idx*BEAT_W +: BEAT_W], so beat 0 carries in_data[511:0] including the sequence number in bits [7:0].
REQ-021 Latency: in_valid sampled in IDLE at edge N SHALL give tvalid=1 with beat 0 after edge N+1.
REQ-022 Handshake: a beat SHALL transfer only on a cycle where tvalid=1 and tready=1.
REQ-023 While tvalid=1 and tready=0, tdata, tkeep and tlast SHALL be held stable, and tvalid SHALL NOT drop.
REQ-024 On each transfer, beat_idx SHALL increment.
REQ-025 tlast SHALL be 1 exactly when beat_idx=NBEATS-1.
REQ-026 tkeep SHALL be all ones on every beat, so the padding bytes are transmitted.
REQ-027 On the transfer of the tlast beat, the FSM SHALL go to DONE and tvalid SHALL be 0 on the following cycle.
REQ-028 DONE: data_next SHALL be 1 for exactly one cycle, frame_cnt SHALL increment (wrapping from 0xFFFFFFFF to 0), and the FSM SHALL return to IDLE.
REQ-029 Minimum frame period SHALL be NBEATS+2 cycles (10 by default) with tready held at 1.
REQ-030 in_valid=1 in SEND or DONE SHALL NOT disturb the captured frame; it SHALL set ovf, which stays 1 until reset.
REQ-031 in_valid asserted in the same cycle as the data_next pulse SHALL be treated as busy (it sets ovf); a frame is accepted only in IDLE.
REQ-032 A tready toggling every cycle SHALL still deliver all NBEATS beats in order, with no beat duplicated or dropped.
REQ-033 beat_idx SHALL be $clog2(NBEATS) bits wide, and the FSM SHALL never index past NBEATS-1.

Reset
REQ-034 On reset, the FSM SHALL be IDLE, beat_idx=0 and the frame register=0.
REQ-035 On reset, every output SHALL be 0: data_next, tvalid, tlast, tdata, tkeep, frame_cnt, ovf and busy.
REQ-036 Reset asserted mid-frame SHALL abort immediately (tvalid to 0 asynchronously), with no data_next and no frame_cnt increment.
REQ-037 After reset is released, the first in_valid SHALL be handled as a fresh frame.

Structure
REQ-038 The shared package c2h_pkg SHALL hold the PACK_W, BEAT_W and NBEATS constants and the state enum typedef (IDLE, SEND, DONE).
REQ-039 No sub-module SHALL be used; the beat mux, FSM and counters SHALL be a single module.

Verification
REQ-040 Basic frame: with tready=1, in_valid pulsed with seq=0x05 and a ramp pattern -> 8 beats on consecutive cycles, beat0[7:0]=0x05, tlast only on beat 7, beat7[511:504]=0, then data_next pulse, frame_cnt=1.
REQ-041 Backpressure: tready=0 for 20 cycles on beat 3 -> tdata is held constant and tvalid stays 1, the remaining beats are correct, and exactly one data_next.
REQ-042 Alternating tready (1010...) for 3 back-to-back frames -> 24 beats in order and frame_cnt=3.
REQ-043 in_valid pulsed during beat 4 -> ovf=1, the stream still carries the original frame, and no second frame starts.
REQ-044 Reset asserted at beat 5 -> tvalid=0 immediately, frame_cnt unchanged, no data_next; the next frame after release is sent whole starting at beat 0.
REQ-045 frame_cnt preloaded via force to 0xFFFFFFFF, then one frame sent -> frame_cnt=0.
